// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for and qualifies lock,
// then releases the downstream reset; re-sequences on lock loss or relock request.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int          TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] STB_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [8:0]       RETRY_LIM = 9'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [7:0]       r_retry;
  logic [7:0]       w_retry_nxt;
  logic [7:0]       r_llc;
  logic [7:0]       w_llc_nxt;
  logic             r_sync1;
  logic             r_lock_s;
  logic             r_pll_rst;
  logic             r_sys_reset_n;
  logic             r_ready;
  logic             r_fault;
  logic [8:0]       w_retry_inc;

  // pll_locked comes from the PLL's own timing; two flops before any decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  assign w_retry_inc = {1'b0, r_retry} + 9'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_retry_nxt = r_retry;
    w_llc_nxt   = r_llc;
    if (relock_req) begin
      w_state_nxt = S_RESET_HOLD;
      w_tmr_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      unique case (r_state)
        S_RESET_HOLD: begin
          if (r_tmr == HOLD_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = S_STABILIZE;
            w_tmr_nxt   = '0;
          end else if (r_tmr == TMO_LAST) begin
            w_retry_nxt = w_retry_inc[7:0];
            w_state_nxt = (w_retry_inc < RETRY_LIM) ? S_RESET_HOLD : S_FAULT;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        S_STABILIZE: begin
          // A lock glitch restarts the wait but is not counted as a failed attempt
          if (!r_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmr_nxt   = '0;
          end else if (r_tmr == STB_LAST) begin
            w_state_nxt = S_RUN;
            w_tmr_nxt   = '0;
            w_retry_nxt = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_state_nxt = S_RESET_HOLD;
            w_tmr_nxt   = '0;
            if (r_llc != 8'hFF) w_llc_nxt = r_llc + 8'd1;
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_RESET_HOLD;
          w_tmr_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the transition edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RESET_HOLD;
      r_tmr         <= '0;
      r_retry       <= '0;
      r_llc         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmr         <= w_tmr_nxt;
      r_retry       <= w_retry_nxt;
      r_llc         <= w_llc_nxt;
      r_pll_rst     <= (w_state_nxt == S_RESET_HOLD) || (w_state_nxt == S_FAULT);
      r_sys_reset_n <= (w_state_nxt == S_RUN);
      r_ready       <= (w_state_nxt == S_RUN);
      r_fault       <= (w_state_nxt == S_FAULT);
    end
  end

  assign pll_rst         = r_pll_rst;
  assign sys_reset_n     = r_sys_reset_n;
  assign ready           = r_ready;
  assign fault           = r_fault;
  assign retry_count     = r_retry;
  assign lock_loss_count = r_llc;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters
// (hold 4, timeout 20, stable 8, 3 retries).
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;

  int total;
  int bad;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       lk;
    logic       rq;
    logic       rst;
    logic       srn;
    logic       rdy;
    logic       flt;
    logic [7:0] rc;
    logic [7:0] llc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int n, logic lk, logic rq, logic rst, logic srn,
                             logic rdy, logic flt, logic [7:0] rc, logic [7:0] llc);
    vec_t r;
    r.n = n; r.lk = lk; r.rq = rq; r.rst = rst; r.srn = srn;
    r.rdy = rdy; r.flt = flt; r.rc = rc; r.llc = llc;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(string name, logic rst, logic srn, logic rdy, logic flt,
                           logic [7:0] rc, logic [7:0] llc);
    total++;
    if ({pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_count} !==
        {rst, srn, rdy, flt, rc, llc}) begin
      bad++;
      $display("FAIL %s: got rst=%b srn=%b rdy=%b flt=%b rc=%0d llc=%0d, want rst=%b srn=%b rdy=%b flt=%b rc=%0d llc=%0d",
               name, pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_count,
               rst, srn, rdy, flt, rc, llc);
    end
  endtask

  task automatic check_bit(string name, logic got, logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_byte(string name, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    logic [7:0] exp_llc;
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;

    // cold start: lock arrives 10 cycles after reset release
    vecs.push_back(v( 3, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v( 7, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(10, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 5, 1, 0, 0, 1, 1, 0, 0, 0));
    // lock loss in RUN, then three timed-out attempts into FAULT
    vecs.push_back(v( 2, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v( 4, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v(20, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v( 4, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(v(20, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v( 4, 0, 0, 1, 0, 0, 0, 2, 1));
    vecs.push_back(v(20, 0, 0, 0, 0, 0, 0, 2, 1));
    vecs.push_back(v(10, 0, 0, 1, 0, 0, 1, 3, 1));
    // relock out of FAULT with lock present
    vecs.push_back(v( 1, 1, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v( 3, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v( 9, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v( 3, 1, 0, 0, 1, 1, 0, 0, 1));
    // relock, then a one-cycle lock glitch seen at stable count 5
    vecs.push_back(v( 1, 1, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v( 3, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v( 5, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v( 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(10, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v( 2, 1, 0, 0, 1, 1, 0, 0, 1));
    // relock in the same cycle lock_s is low: no lock-loss count
    vecs.push_back(v( 2, 0, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(v( 1, 0, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v( 3, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v( 9, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v( 3, 1, 0, 0, 1, 1, 0, 0, 1));

    repeat (3) @(negedge clk);
    check_all("reset_state", 1, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      pll_locked = vecs[i].lk;
      relock_req = vecs[i].rq;
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc();
        relock_req = 1'b0;
        check_all($sformatf("vec%0d_cyc%0d", i, k), vecs[i].rst, vecs[i].srn,
                  vecs[i].rdy, vecs[i].flt, vecs[i].rc, vecs[i].llc);
      end
    end

    // repeated lock loss: counter saturates at 255
    exp_llc = 8'd1;
    for (int it = 0; it < 300; it++) begin
      pll_locked = 1'b0;
      repeat (3) cyc();
      if (exp_llc != 8'hFF) exp_llc = exp_llc + 8'd1;
      if (lock_loss_count !== exp_llc || ready !== 1'b0) begin
        check_byte($sformatf("llc_iter%0d", it), lock_loss_count, exp_llc);
        check_bit($sformatf("drop_iter%0d", it), ready, 1'b0);
      end else begin
        total++;
      end
      pll_locked = 1'b1;
      for (int k = 0; k < 60 && !ready; k++) cyc();
      if (!ready) begin
        check_bit($sformatf("relock_timeout_iter%0d", it), ready, 1'b1);
        break;
      end
    end
    check_byte("llc_saturated", lock_loss_count, 8'd255);

    // asynchronous reset mid-STABILIZE
    relock_req = 1'b1;
    cyc();
    relock_req = 1'b0;
    repeat (6) cyc();
    check_all("in_stabilize", 0, 0, 0, 0, 0, 255);
    #2 reset_n = 1'b0;
    #1 check_all("async_reset", 1, 0, 0, 0, 0, 0);
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    check_bit("post_reset_hold", pll_rst, 1'b1);
    cyc();
    check_bit("post_reset_release", pll_rst, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
